// File: rtl/output_dp_mem_2048b_32b.sv
`default_nettype none
// ============================================================================
// Module      : output_dp_mem_2048b_32b
// Description : Matmul result buffer. 2048-bit rows are written on a valid/ready
//               handshake and read back as 32-bit words over an AXI BRAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module output_dp_mem_2048b_32b #(
    parameter int DATA_W        = 32,
    parameter int WORDS_PER_ROW = 64,
    parameter int ROWS          = 64,
    parameter int ADDR_W        = 12
) (
    input  wire logic                              clk,
    input  wire logic                              rst_n,
    input  wire logic                              i_start,
    input  wire logic                              i_row_valid,
    output logic                                   o_row_ready,
    input  wire logic [DATA_W*WORDS_PER_ROW-1:0]   i_row_data,
    input  wire logic                              i_en_a,
    input  wire logic [ADDR_W-1:0]                 i_addr_a,
    output logic [DATA_W-1:0]                      o_dout_a,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic                                   o_done_pulse,
    output logic [$clog2(ROWS+1)-1:0]              o_row_count,
    output logic                                   o_overflow_err
);

    localparam int PTR_W  = $clog2(ROWS);
    localparam int WSEL_W = $clog2(WORDS_PER_ROW);
    localparam int CNT_W  = $clog2(ROWS+1);

    localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(ROWS);
    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(ROWS-1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_row_ptr;
    logic [CNT_W-1:0]   r_row_count;
    logic               r_done_pulse;
    logic               r_overflow_err;
    logic [DATA_W-1:0]  r_dout;

    logic               w_wr_en;
    logic [PTR_W-1:0]   w_rd_row;
    logic [WSEL_W-1:0]  w_rd_bank;
    logic [DATA_W-1:0]  w_bank_rd [WORDS_PER_ROW];

    assign o_row_ready    = (r_state == S_COLLECT);
    assign o_busy         = (r_state == S_COLLECT);
    assign o_done         = (r_state == S_DONE);
    assign o_done_pulse   = r_done_pulse;
    assign o_row_count    = r_row_count;
    assign o_overflow_err = r_overflow_err;
    assign o_dout_a       = r_dout;

    assign w_wr_en   = i_row_valid & o_row_ready;
    assign w_rd_row  = i_addr_a[ADDR_W-1 -: PTR_W];
    assign w_rd_bank = i_addr_a[WSEL_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_row_ptr      <= '0;
            r_row_count    <= '0;
            r_done_pulse   <= 1'b0;
            r_overflow_err <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state        <= S_COLLECT;
                        r_row_ptr      <= '0;
                        r_row_count    <= '0;
                        r_overflow_err <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (i_row_valid) begin
                        r_row_ptr <= r_row_ptr + 1'b1;
                        if (r_row_count != c_CNT_MAX) begin
                            r_row_count <= r_row_count + 1'b1;
                        end
                        if (r_row_ptr == c_PTR_LAST) begin
                            r_state      <= S_DONE;
                            r_done_pulse <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (i_start) begin
                        r_state        <= S_COLLECT;
                        r_row_ptr      <= '0;
                        r_row_count    <= '0;
                        r_overflow_err <= 1'b0;
                    end else if (i_row_valid) begin
                        r_overflow_err <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Word 0 of a row sits in the most significant slice of i_row_data.
    for (genvar b = 0; b < WORDS_PER_ROW; b++) begin : g_bank
        logic [DATA_W-1:0] r_mem [ROWS];

        always_ff @(posedge clk) begin
            if (w_wr_en) begin
                r_mem[r_row_ptr] <= i_row_data[(WORDS_PER_ROW-1-b)*DATA_W +: DATA_W];
            end
        end

        assign w_bank_rd[b] = r_mem[w_rd_row];
    end

    // Banks are read before this edge's write lands, giving read-first collisions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (i_en_a) begin
            r_dout <= w_bank_rd[w_rd_bank];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_dp_mem_2048b_32b.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_dp_mem_2048b_32b
// Description : Directed self-checking bench; AXI reads are scored from a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_dp_mem_2048b_32b;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          row_valid = 1'b0;
    logic          row_ready;
    logic [2047:0] row_data = '0;
    logic          en_a = 1'b0;
    logic [11:0]   addr_a = '0;
    logic [31:0]   dout_a;
    logic          busy;
    logic          done;
    logic          done_pulse;
    logic [6:0]    row_count;
    logic          overflow_err;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] exp;
    } rd_t;

    rd_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    output_dp_mem_2048b_32b dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (start),
        .i_row_valid    (row_valid),
        .o_row_ready    (row_ready),
        .i_row_data     (row_data),
        .i_en_a         (en_a),
        .i_addr_a       (addr_a),
        .o_dout_a       (dout_a),
        .o_busy         (busy),
        .o_done         (done),
        .o_done_pulse   (done_pulse),
        .o_row_count    (row_count),
        .o_overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [2047:0] mk_row(input int r, input logic [15:0] tag);
        logic [2047:0] d;
        logic [7:0]    rb;
        logic [7:0]    jb;
        d  = '0;
        rb = r[7:0];
        for (int j = 0; j < 64; j++) begin
            jb = j[7:0];
            d[2047-32*j -: 32] = {rb, jb, tag};
        end
        return d;
    endfunction

    // Issue a read this cycle and queue its expected data.
    task automatic rd(input logic [11:0] a, input logic [31:0] exp);
        rd_t e;
        en_a   = 1'b1;
        addr_a = a;
        e.addr = a;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    task automatic chk_status(input string tag, input logic b, input logic d,
                              input logic [6:0] cnt, input logic ovf);
        chk({tag, " busy"},      {31'd0, busy},         {31'd0, b});
        chk({tag, " row_ready"}, {31'd0, row_ready},    {31'd0, b});
        chk({tag, " done"},      {31'd0, done},         {31'd0, d});
        chk({tag, " row_count"}, {25'd0, row_count},    {25'd0, cnt});
        chk({tag, " overflow"},  {31'd0, overflow_err}, {31'd0, ovf});
    endtask

    // Monitor: a read sampled at an edge presents its data just after that edge.
    initial begin
        logic v;
        rd_t  e;
        forever begin
            @(posedge clk);
            v = en_a;
            #2;
            if (v) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL read_unexpected: got %h expected none", dout_a);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("read addr %h", e.addr), dout_a, e.exp);
                end
            end
        end
    end

    initial begin
        // T1 reset
        tick();
        tick();
        chk_status("T1", 1'b0, 1'b0, 7'd0, 1'b0);
        chk("T1 done_pulse", {31'd0, done_pulse}, 32'd0);
        chk("T1 dout_a", dout_a, 32'd0);
        rst_n = 1'b1;
        tick();

        // T2 full tile back-to-back
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_status("T2 armed", 1'b1, 1'b0, 7'd0, 1'b0);
        for (int r = 0; r < 64; r++) begin
            row_valid = 1'b1;
            row_data  = mk_row(r, 16'hA5A5);
            tick();
        end
        row_valid = 1'b0;
        chk_status("T2 end", 1'b0, 1'b1, 7'd64, 1'b0);
        chk("T2 done_pulse high", {31'd0, done_pulse}, 32'd1);
        rd(12'h143, 32'h0503A5A5);
        tick();
        chk("T2 done_pulse low", {31'd0, done_pulse}, 32'd0);
        rd(12'hFFF, 32'h3F3FA5A5);
        tick();
        rd(12'h000, 32'h0000A5A5);
        tick();
        en_a = 1'b0;
        tick();
        chk("T2 dout hold", dout_a, 32'h0000A5A5);

        // T4 overrun in DONE
        row_valid = 1'b1;
        row_data  = '1;
        tick();
        row_valid = 1'b0;
        chk_status("T4 overrun", 1'b0, 1'b1, 7'd64, 1'b1);
        rd(12'h000, 32'h0000A5A5);
        tick();
        en_a  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_status("T4 restart", 1'b1, 1'b0, 7'd0, 1'b0);

        // T3 rows on alternate cycles
        for (int r = 0; r < 64; r++) begin
            row_valid = 1'b1;
            row_data  = mk_row(r, 16'h5A5A);
            tick();
            row_valid = 1'b0;
            chk("T3 count", {25'd0, row_count}, r + 1);
            chk("T3 done", {31'd0, done}, (r == 63) ? 32'd1 : 32'd0);
            tick();
            chk("T3 gap count", {25'd0, row_count}, r + 1);
        end
        chk("T3 done_pulse gone", {31'd0, done_pulse}, 32'd0);
        rd(12'h143, 32'h05035A5A);
        tick();
        en_a = 1'b0;

        // T5 read/write collision at row 2
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            row_valid = 1'b1;
            row_data  = mk_row(r, 16'hA5A5);
            tick();
        end
        row_data = mk_row(2, 16'hC3C3);
        rd(12'h080, 32'h02005A5A);
        tick();
        row_valid = 1'b0;
        rd(12'h080, 32'h0200C3C3);
        tick();
        en_a = 1'b0;

        // T6 reset mid-tile, with an ignored start at row 5
        for (int r = 3; r < 10; r++) begin
            row_valid = 1'b1;
            row_data  = mk_row(r, 16'hA5A5);
            start     = (r == 5);
            tick();
        end
        row_valid = 1'b0;
        start     = 1'b0;
        chk_status("T6 ten rows", 1'b1, 1'b0, 7'd10, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_status("T6 reset", 1'b0, 1'b0, 7'd0, 1'b0);
        chk("T6 dout reset", dout_a, 32'd0);
        row_valid = 1'b1;
        row_data  = '1;
        tick();
        row_valid = 1'b0;
        chk_status("T6 idle valid", 1'b0, 1'b0, 7'd0, 1'b0);
        rd(12'h240, 32'h0900A5A5);
        tick();
        rd(12'h000, 32'h0000A5A5);
        tick();
        rd(12'h080, 32'h0200C3C3);
        tick();
        en_a = 1'b0;
        tick();
        tick();
        chk("T6 dout hold", dout_a, 32'h0200C3C3);

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL read_queue_drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
